// File: rtl/dmux_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmux_scheduler_pkg
// Description : Shared encodings and helpers for the demux sequencing
//               controller: FSM state codes, routing-mode codes and the
//               watchdog counter width function.
// Revision    : 1.0 - initial release
// ============================================================================
package dmux_scheduler_pkg;

    // FSM state encoding (1 bit: register empty / word held)
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Routing mode encoding
    localparam logic MODE_RR   = 1'b0;
    localparam logic MODE_ADDR = 1'b1;

    // Watchdog counter width: enough to hold TIMEOUT, never narrower than 1.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : dmux_scheduler_pkg
`default_nettype wire

// File: rtl/dmux_scheduler_dmux1bit.sv
`default_nettype none
// ============================================================================
// Module      : dmux_scheduler_dmux1bit
// Description : 1-bit demultiplexer. Steers din onto output bit sel; every
//               other output bit is 0. Used to build the one-hot channel
//               valid vector.
// Ports       : sel  [NB_SEL-1:0]     - selected output
//               din                   - bit to steer
//               dout [2**NB_SEL-1:0]  - one-hot (or zero) result
// Revision    : 1.0 - initial release
// ============================================================================
module dmux_scheduler_dmux1bit #(
    parameter int NB_SEL = 2
) (
    input  logic [NB_SEL-1:0]      sel,
    input  logic                   din,
    output logic [2**NB_SEL-1:0]   dout
);

    for (genvar k = 0; k < 2**NB_SEL; k++) begin : g_ch
        assign dout[k] = din & (sel == NB_SEL'(k));
    end

endmodule : dmux_scheduler_dmux1bit
`default_nettype wire

// File: rtl/dmux_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dmux_scheduler
// Description : Sequencing controller in front of a one-hot channel demux.
//               Accepts one word per cycle from a producer (valid/ready),
//               routes it round-robin or by address to one of 2**NB_SEL
//               channels, holds it in a one-entry output register until the
//               selected consumer takes it, and drops it (with a one-cycle
//               drop pulse) if it waits TIMEOUT cycles.
// Ports       : clk, rst_n             - clock, async active-low reset
//               mode                   - 0 round-robin, 1 addressed
//               in_data/in_dest        - producer word / destination
//               in_valid/in_ready      - producer handshake
//               out_data               - held word (broadcast)
//               out_valid [N]          - one-hot channel offer
//               out_ready [N]          - per-channel consumer ready
//               drop                   - watchdog discard pulse
//               cur_sel                - channel of the held word
// Revision    : 1.0 - initial release
// ============================================================================
module dmux_scheduler
    import dmux_scheduler_pkg::*;
#(
    parameter int BUS_WIDTH = 8,
    parameter int NB_SEL    = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode,
    input  logic [BUS_WIDTH-1:0]   in_data,
    input  logic [NB_SEL-1:0]      in_dest,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [BUS_WIDTH-1:0]   out_data,
    output logic [2**NB_SEL-1:0]   out_valid,
    input  logic [2**NB_SEL-1:0]   out_ready,
    output logic                   drop,
    output logic [NB_SEL-1:0]      cur_sel
);

    localparam int N  = 2**NB_SEL;
    localparam int CW = cnt_width(TIMEOUT);

    localparam logic [CW-1:0]     c_cnt_one  = CW'(1);
    localparam logic [CW-1:0]     c_tmo_last = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [NB_SEL-1:0] c_ptr_one  = NB_SEL'(1);

    // Registered state
    logic [0:0]           r_state;
    logic [BUS_WIDTH-1:0] r_data;
    logic [NB_SEL-1:0]    r_sel;
    logic [NB_SEL-1:0]    r_rr_ptr;
    logic [CW-1:0]        r_wait_cnt;
    logic                 r_drop;
    logic [N-1:0]         r_out_valid;

    // Next-state / handshake terms
    logic [0:0]           w_nxt_state;
    logic [BUS_WIDTH-1:0] w_nxt_data;
    logic [NB_SEL-1:0]    w_nxt_sel;
    logic [NB_SEL-1:0]    w_nxt_ptr;
    logic [CW-1:0]        w_nxt_cnt;
    logic                 w_nxt_drop;
    logic [N-1:0]         w_nxt_onehot;
    logic                 w_handoff;
    logic                 w_expire;
    logic                 w_accept;
    logic [NB_SEL-1:0]    w_route;

    // Only the selected channel's ready matters; other bits are ignored.
    assign w_handoff = (r_state == ST_HOLD) && out_ready[r_sel];

    // Expiry only when no handoff, so a late handoff always wins.
    assign w_expire  = (TIMEOUT != 0) && (r_state == ST_HOLD) && !w_handoff
                       && (r_wait_cnt == c_tmo_last);

    // Ready is independent of in_valid; it is low on the expiry cycle
    // because that cycle has no handoff by construction.
    assign in_ready  = (r_state == ST_IDLE) || w_handoff;
    assign w_accept  = in_valid && in_ready;
    assign w_route   = (mode == MODE_ADDR) ? in_dest : r_rr_ptr;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_data  = r_data;
        w_nxt_sel   = r_sel;
        w_nxt_ptr   = r_rr_ptr;
        w_nxt_cnt   = r_wait_cnt;
        w_nxt_drop  = 1'b0;

        if (w_accept) begin
            // Entry to HOLD or back-to-back reload
            w_nxt_state = ST_HOLD;
            w_nxt_data  = in_data;
            w_nxt_sel   = w_route;
            w_nxt_cnt   = '0;
            if (mode == MODE_RR) begin
                w_nxt_ptr = r_rr_ptr + c_ptr_one;
            end
        end else if (w_handoff) begin
            w_nxt_state = ST_IDLE;
        end else if (w_expire) begin
            w_nxt_state = ST_IDLE;
            w_nxt_drop  = 1'b1;
        end else if ((r_state == ST_HOLD) && (TIMEOUT != 0)) begin
            w_nxt_cnt = r_wait_cnt + c_cnt_one;
        end
    end

    // Decode the next-cycle offer so out_valid comes straight from a flop.
    dmux_scheduler_dmux1bit #(
        .NB_SEL (NB_SEL)
    ) u_valid_dmux (
        .sel  (w_nxt_sel),
        .din  (w_nxt_state == ST_HOLD),
        .dout (w_nxt_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_data      <= '0;
            r_sel       <= '0;
            r_rr_ptr    <= '0;
            r_wait_cnt  <= '0;
            r_drop      <= 1'b0;
            r_out_valid <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_data      <= w_nxt_data;
            r_sel       <= w_nxt_sel;
            r_rr_ptr    <= w_nxt_ptr;
            r_wait_cnt  <= w_nxt_cnt;
            r_drop      <= w_nxt_drop;
            r_out_valid <= w_nxt_onehot;
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_out_valid;
    assign cur_sel   = r_sel;
    assign drop      = r_drop;

endmodule : dmux_scheduler
`default_nettype wire

// File: doc/dmux_scheduler.md
# dmux_scheduler

Sequencing controller that drives a demultiplexer: it accepts one word at a time from a single producer over a valid/ready handshake and routes it to one of 2**NB_SEL consumer channels. Routing is either round-robin or addressed. Each word is held in a one-entry output register until the selected consumer accepts it; a stall watchdog drops words that wait too long. It sits between a producer (e.g. decode or load unit) and the one-hot channel fan-out built on the dmux family.

## Interface
- BUS_WIDTH, 8, data word width
- NB_SEL, 2, select width; channel count N = 2**NB_SEL
- TIMEOUT, 16, max cycles a held word waits for its consumer; 0 disables the watchdog
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- mode  in  1  0 = round-robin, 1 = addressed; sampled only on input accept
- in_data  in  BUS_WIDTH  producer word
- in_dest  in  NB_SEL  destination channel, used when mode=1
- in_valid  in  1  producer has a word
- in_ready  out  1  scheduler can accept this cycle
- out_data  out  BUS_WIDTH  held word, broadcast to all channels
- out_valid  out  N  one-hot: bit k = word is offered to channel k
- out_ready  in  N  per-channel consumer ready
- drop  out  1  one-cycle pulse: held word discarded by watchdog
- cur_sel  out  NB_SEL  channel of the held word (debug/observability)

## Operation
- Two states: IDLE (register empty), HOLD (word held, out_valid one-hot nonzero).
- Accept = in_valid & in_ready. Selected channel: in_dest if mode=1, else round-robin pointer rr_ptr.
- in_ready = (state==IDLE) | (state==HOLD & out_ready[cur_sel]); combinational, no dependency on in_valid.
- IDLE + accept -> HOLD: latch in_data, selected channel; out_valid = 1<<sel.
- HOLD + out_ready[cur_sel] (handoff): if accept in same cycle, reload and stay HOLD (back-to-back); else -> IDLE, out_valid=0.
- HOLD, no handoff: out_data, out_valid, cur_sel held stable; out_ready on non-selected bits ignored.
- rr_ptr advances by 1 modulo N (N-1 wraps to 0) on each round-robin accept only; addressed accepts leave it unchanged.
- Watchdog: wait_cnt clears on entry to HOLD/reload, increments each HOLD cycle without handoff. When wait_cnt==TIMEOUT-1 with no handoff: next edge -> IDLE, out_valid=0, drop=1 for one cycle; no accept that cycle (in_ready=0). TIMEOUT=0: never drops.
- Mode change while in HOLD has no effect on the held word.

## Timing
- Reset values (async, immediate on rst_n=0): state IDLE, out_valid=0, out_data=0, cur_sel=0, rr_ptr=0, wait_cnt=0, drop=0. in_ready=1 once rst_n is high.
- Reset mid-HOLD: held word lost, no drop pulse.
- Latency: accept at edge t -> out_valid at t+1 (registered).
- Throughput: 1 word/cycle when the selected consumer is ready each cycle.
- Handoff and watchdog expiry in the same cycle: handoff wins, no drop.
- All outputs except in_ready are registered.

## Structure
- Shared include src/multiplexing/mux_defs.vh: state encodings (ST_IDLE=0, ST_HOLD=1), mode encodings (MODE_RR=0, MODE_ADDR=1).
- One sub-module is natural: the existing dmux1bit (NB_SEL) generates the one-hot out_valid from cur_sel and the valid bit.
- Counter width: $clog2(TIMEOUT+1), minimum 1.

## Test plan
- Reset: drive rst_n=0 mid-HOLD -> out_valid=0, out_data=0, rr_ptr=0 immediately; in_ready=1 after release.
- Round-robin: mode=0, all out_ready=1, 5 back-to-back words 0xA0..0xA4 -> out_valid 0001,0010,0100,1000,0001, one per cycle, data in order.
- Addressed + backpressure: mode=1, in_dest=2, out_ready[2]=0 for 3 cycles -> out_valid=0100 and data stable for 4 cycles, in_ready=0 until out_ready[2]=1.
- Watchdog: TIMEOUT=4, out_ready=0 -> drop=1 exactly 4 cycles after out_valid rises, then out_valid=0 and state IDLE.
- Simultaneous: handoff on the expiry cycle -> no drop; handoff with a new accept -> new word presented the next cycle with no bubble.
- Mode mix: RR accept (ptr 0->1), addressed accept to 3, RR accept -> goes to channel 1, showing the pointer is untouched by addressed accepts.
